card_deck: RTL and testbench

CARD_DECK -- requirements
Module: card_deck

---
 rtl/card_deck_pkg.sv | 31 +++
 rtl/lfsr6.sv | 37 +++
 rtl/card_deck.sv | 174 +++++++++++++++++
 tb/tb_card_deck.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_deck_pkg.sv
// card_deck_pkg: constants, card encoding and FSM state type shared by the card deck block.
//   DECK_SIZE  - number of cards in a full deck
//   RANK_MAX   - highest rank (king); ranks run 1..RANK_MAX
//   SUIT_*     - 2-bit suit encodings
//   card_t     - packed {suit, rank} card code, 6 bits
//   state_e    - deck controller states
package card_deck_pkg;

   localparam int unsigned DECK_SIZE = 52;
   localparam logic [3:0]  RANK_MAX  = 4'd13;
   localparam logic [5:0]  LAST_IDX  = 6'(DECK_SIZE - 1);
   localparam logic [5:0]  FULL_CNT  = 6'(DECK_SIZE);

   localparam logic [1:0] SUIT_CLUBS    = 2'd0;
   localparam logic [1:0] SUIT_DIAMONDS = 2'd1;
   localparam logic [1:0] SUIT_HEARTS   = 2'd2;
   localparam logic [1:0] SUIT_SPADES   = 2'd3;

   typedef struct packed {
      logic [1:0] suit;
      logic [3:0] rank;
   } card_t;

   typedef enum logic [1:0] {
      StLoad,
      StPick,
      StSwap,
      StReady
   } state_e;

endpackage

// File: rtl/lfsr6.sv
// lfsr6: 6-bit Fibonacci LFSR, polynomial x^6 + x^5 + 1 (maximal length, period 63).
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset, loads SEED (0 is replaced by 1)
//   en    - advance one step this cycle
//   value - current LFSR state, never 0
module lfsr6 #(
   parameter logic [5:0] SEED = 6'b011110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [5:0] value
);

   // An all-zero state would lock the register up.
   localparam logic [5:0] SeedEff = (SEED == 6'd0) ? 6'd1 : SEED;

   logic [5:0] value_q, value_d;

   always_comb begin
      value_d = value_q;
      if (en) begin
         value_d = {value_q[4:0], value_q[5] ^ value_q[4]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= SeedEff;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/card_deck.sv
// card_deck: 52-card deck that loads in order, Fisher-Yates shuffles using lfsr6, then deals
// one card per accepted draw.
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset; restarts load and shuffle from SEED
//   draw       - request one card (honoured only when ready and cards remain)
//   reshuffle  - rebuild and reshuffle the deck (honoured only when ready; beats draw)
//   ready      - deck shuffled and able to serve draws
//   card_valid - one-cycle pulse: card_rank/card_suit hold a newly drawn card
//   card_rank  - 1 (ace) .. 13 (king), held between draws
//   card_suit  - 0 .. 3, held between draws
//   cards_left - undrawn cards remaining, 0 .. 52
//   deck_empty - ready and no cards left
module card_deck
   import card_deck_pkg::*;
#(
   parameter logic [5:0] SEED       = 6'b011110,
   parameter bit         SHUFFLE_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       draw,
   input  logic       reshuffle,
   output logic       ready,
   output logic       card_valid,
   output logic [3:0] card_rank,
   output logic [1:0] card_suit,
   output logic [5:0] cards_left,
   output logic       deck_empty
);

   state_e     state_q, state_d;
   logic [5:0] k_q, k_d;
   logic [5:0] i_q, i_d;
   logic [5:0] j_q, j_d;
   logic [5:0] ptr_q, ptr_d;
   logic [5:0] left_q, left_d;
   logic [1:0] suit_cnt_q, suit_cnt_d;
   logic [3:0] rank_cnt_q, rank_cnt_d;
   card_t      card_q, card_d;
   logic       valid_q, valid_d;

   // Deck storage needs no reset: every load pass rewrites all entries.
   card_t      deck_q [DECK_SIZE];

   logic [5:0] lfsr_value;
   logic [5:0] cand;
   logic       lfsr_en;

   // The LFSR only steps while picking, so a reshuffle continues the sequence.
   assign lfsr_en = (state_q == StPick);
   // LFSR never holds 0, so the candidate index spans 0..62.
   assign cand    = lfsr_value - 6'd1;

   lfsr6 #(
      .SEED(SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (lfsr_en),
      .value(lfsr_value)
   );

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      i_d        = i_q;
      j_d        = j_q;
      ptr_d      = ptr_q;
      left_d     = left_q;
      suit_cnt_d = suit_cnt_q;
      rank_cnt_d = rank_cnt_q;
      card_d     = card_q;
      valid_d    = 1'b0;

      unique case (state_q)
         StLoad: begin
            // Rank wraps 13 -> 1 and carries into suit: k/13 and k%13+1 without a divider.
            k_d = k_q + 6'd1;
            if (rank_cnt_q == RANK_MAX) begin
               rank_cnt_d = 4'd1;
               suit_cnt_d = suit_cnt_q + 2'd1;
            end else begin
               rank_cnt_d = rank_cnt_q + 4'd1;
            end
            if (k_q == LAST_IDX) begin
               k_d        = 6'd0;
               rank_cnt_d = 4'd1;
               suit_cnt_d = 2'd0;
               i_d        = LAST_IDX;
               if (SHUFFLE_EN) begin
                  state_d = StPick;
               end else begin
                  state_d = StReady;
                  ptr_d   = 6'd0;
                  left_d  = FULL_CNT;
               end
            end
         end
         StPick: begin
            // Rejection sampling keeps j uniform-ish over 0..i.
            if (cand <= i_q) begin
               j_d     = cand;
               state_d = StSwap;
            end
         end
         StSwap: begin
            i_d = i_q - 6'd1;
            if (i_q > 6'd1) begin
               state_d = StPick;
            end else begin
               state_d = StReady;
               ptr_d   = 6'd0;
               left_d  = FULL_CNT;
            end
         end
         StReady: begin
            if (reshuffle) begin
               state_d = StLoad;
               left_d  = 6'd0;
            end else if (draw && (left_q != 6'd0)) begin
               valid_d = 1'b1;
               card_d  = deck_q[ptr_q];
               ptr_d   = ptr_q + 6'd1;
               left_d  = left_q - 6'd1;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StLoad;
         k_q        <= 6'd0;
         i_q        <= LAST_IDX;
         j_q        <= 6'd0;
         ptr_q      <= 6'd0;
         left_q     <= 6'd0;
         suit_cnt_q <= 2'd0;
         rank_cnt_q <= 4'd1;
         card_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         i_q        <= i_d;
         j_q        <= j_d;
         ptr_q      <= ptr_d;
         left_q     <= left_d;
         suit_cnt_q <= suit_cnt_d;
         rank_cnt_q <= rank_cnt_d;
         card_q     <= card_d;
         valid_q    <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StLoad) begin
         deck_q[k_q] <= '{suit: suit_cnt_q, rank: rank_cnt_q};
      end else if (state_q == StSwap) begin
         // When i == j both writes carry the same value.
         deck_q[i_q] <= deck_q[j_q];
         deck_q[j_q] <= deck_q[i_q];
      end
   end

   assign ready      = (state_q == StReady);
   assign card_valid = valid_q;
   assign card_rank  = card_q.rank;
   assign card_suit  = card_q.suit;
   assign cards_left = left_q;
   assign deck_empty = ready && (left_q == 6'd0);

endmodule

// File: tb/tb_card_deck.sv
// tb_card_deck: scoreboard bench for card_deck. Two instances: u_plain (no shuffle, load order)
// and u_shuf (shuffled from the default seed). Expected card codes are queued when a draw is
// issued and popped by per-instance monitors whenever card_valid is seen.
module tb_card_deck;

   localparam logic [5:0] Seed = 6'b011110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       p_rst, p_draw, p_resh, p_ready, p_valid, p_empty;
   logic [3:0] p_rank;
   logic [1:0] p_suit;
   logic [5:0] p_left;

   logic       s_rst, s_draw, s_resh, s_ready, s_valid, s_empty;
   logic [3:0] s_rank;
   logic [1:0] s_suit;
   logic [5:0] s_left;

   card_deck #(
      .SEED      (Seed),
      .SHUFFLE_EN(1'b0)
   ) u_plain (
      .clk       (clk),
      .rst       (p_rst),
      .draw      (p_draw),
      .reshuffle (p_resh),
      .ready     (p_ready),
      .card_valid(p_valid),
      .card_rank (p_rank),
      .card_suit (p_suit),
      .cards_left(p_left),
      .deck_empty(p_empty)
   );

   card_deck #(
      .SEED      (Seed),
      .SHUFFLE_EN(1'b1)
   ) u_shuf (
      .clk       (clk),
      .rst       (s_rst),
      .draw      (s_draw),
      .reshuffle (s_resh),
      .ready     (s_ready),
      .card_valid(s_valid),
      .card_rank (s_rank),
      .card_suit (s_suit),
      .cards_left(s_left),
      .deck_empty(s_empty)
   );

   int checks = 0;
   int errors = 0;

   logic [5:0] p_exp_q[$];
   logic [5:0] s_exp_q[$];

   // Reference deck and LFSR state, built from the load order and Fisher-Yates definition.
   logic [5:0] deck_m [52];
   logic [5:0] lfsr_m;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] load_code(input int k);
      return {2'(k / 13), 4'(k % 13 + 1)};
   endfunction

   task automatic model_shuffle();
      logic [5:0] j;
      logic [5:0] t;
      for (int k = 0; k < 52; k++) deck_m[k] = load_code(k);
      for (int i = 51; i >= 1; i--) begin
         do begin
            j      = lfsr_m - 6'd1;
            lfsr_m = {lfsr_m[4:0], lfsr_m[5] ^ lfsr_m[4]};
         end while (j > 6'(i));
         t         = deck_m[i];
         deck_m[i] = deck_m[j];
         deck_m[j] = t;
      end
   endtask

   task automatic wait_ready(input bit shuf, output int n);
      n = 0;
      while (!(shuf ? s_ready : p_ready) && n < 6000) begin
         tick();
         n++;
      end
      chk(shuf ? "shuf ready timeout" : "plain ready timeout",
          int'(shuf ? s_ready : p_ready), 1);
   endtask

   always @(negedge clk) begin
      if (p_valid) begin
         if (p_exp_q.size() == 0) chk("plain unexpected card_valid", int'(p_valid), 0);
         else chk("plain card code", int'({p_suit, p_rank}), int'(p_exp_q.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (s_valid) begin
         if (s_exp_q.size() == 0) chk("shuf unexpected card_valid", int'(s_valid), 0);
         else chk("shuf card code", int'({s_suit, s_rank}), int'(s_exp_q.pop_front()));
      end
   end

   initial begin
      int n;
      int mleft;
      int sptr;

      p_rst = 1'b1; p_draw = 1'b0; p_resh = 1'b0;
      s_rst = 1'b1; s_draw = 1'b0; s_resh = 1'b0;
      repeat (2) tick();
      // Requests during reset are ignored.
      p_draw = 1'b1; p_resh = 1'b1;
      tick();
      p_draw = 1'b0; p_resh = 1'b0;
      chk("reset ready", int'(p_ready), 0);
      chk("reset card_valid", int'(p_valid), 0);
      chk("reset card_rank", int'(p_rank), 0);
      chk("reset card_suit", int'(p_suit), 0);
      chk("reset cards_left", int'(p_left), 0);
      chk("reset deck_empty", int'(p_empty), 0);

      // ---- Unshuffled deck: load takes exactly 52 cycles, then deals in load order.
      p_rst = 1'b0;
      wait_ready(1'b0, n);
      chk("plain load cycles", n, 52);
      chk("plain cards_left full", int'(p_left), 52);
      chk("plain deck_empty full", int'(p_empty), 0);

      // Draw held from the first ready cycle: 52 cards back to back, then nothing.
      mleft  = 52;
      p_draw = 1'b1;
      for (int c = 0; c < 54; c++) begin
         if (mleft > 0) begin
            p_exp_q.push_back(load_code(52 - mleft));
            mleft--;
         end
         tick();
         chk("plain valid run", int'(p_valid), int'(c < 52));
         chk("plain cards_left step", int'(p_left), mleft);
      end
      chk("plain deck_empty", int'(p_empty), 1);
      chk("plain rank held", int'(p_rank), 13);
      chk("plain suit held", int'(p_suit), 3);

      // Reshuffle with draw still high; reshuffle kept high during load must be ignored.
      p_resh = 1'b1;
      tick();
      chk("plain reshuffle ready low", int'(p_ready), 0);
      chk("plain reshuffle no card", int'(p_valid), 0);
      chk("plain reshuffle cards_left", int'(p_left), 0);
      chk("plain reshuffle deck_empty", int'(p_empty), 0);
      repeat (5) tick();
      p_resh = 1'b0;
      p_draw = 1'b0;
      wait_ready(1'b0, n);
      chk("plain reload cycles", n + 5, 52);
      chk("plain reload cards_left", int'(p_left), 52);
      p_exp_q.push_back(load_code(0));
      p_draw = 1'b1;
      tick();
      p_draw = 1'b0;
      chk("plain single draw valid", int'(p_valid), 1);
      chk("plain single draw left", int'(p_left), 51);
      tick();
      chk("plain pulse ends", int'(p_valid), 0);
      chk("plain rank after gap", int'(p_rank), 1);

      // ---- Shuffled deck: reset in the middle of the shuffle, restart from the seed.
      s_rst = 1'b0;
      repeat (60) tick();
      chk("shuf not ready mid-shuffle", int'(s_ready), 0);
      s_rst = 1'b1;
      repeat (2) tick();
      chk("shuf reset cards_left", int'(s_left), 0);
      chk("shuf reset valid", int'(s_valid), 0);
      s_rst  = 1'b0;
      lfsr_m = Seed;
      model_shuffle();
      wait_ready(1'b1, n);
      chk("shuf cards_left full", int'(s_left), 52);

      // Ten separated draws; outputs hold between them.
      sptr = 0;
      for (int c = 0; c < 10; c++) begin
         s_exp_q.push_back(deck_m[sptr]);
         sptr++;
         s_draw = 1'b1;
         tick();
         s_draw = 1'b0;
         chk("shuf draw valid", int'(s_valid), 1);
         chk("shuf draw cards_left", int'(s_left), 52 - sptr);
         tick();
         chk("shuf gap valid", int'(s_valid), 0);
         chk("shuf rank held", int'(s_rank), int'(deck_m[sptr - 1][3:0]));
      end

      // Reshuffle and draw together: reshuffle wins, LFSR continues, new order.
      s_resh = 1'b1;
      s_draw = 1'b1;
      tick();
      s_resh = 1'b0;
      s_draw = 1'b0;
      chk("shuf reshuffle ready low", int'(s_ready), 0);
      chk("shuf reshuffle no card", int'(s_valid), 0);
      chk("shuf reshuffle cards_left", int'(s_left), 0);
      model_shuffle();
      wait_ready(1'b1, n);
      chk("shuf reshuffled cards_left", int'(s_left), 52);

      mleft  = 52;
      s_draw = 1'b1;
      for (int c = 0; c < 54; c++) begin
         if (mleft > 0) begin
            s_exp_q.push_back(deck_m[52 - mleft]);
            mleft--;
         end
         tick();
         chk("shuf valid run", int'(s_valid), int'(c < 52));
         chk("shuf cards_left step", int'(s_left), mleft);
      end
      s_draw = 1'b0;
      chk("shuf deck_empty", int'(s_empty), 1);

      // Reset after a complete shuffle: same deal as the first one from the seed.
      s_rst = 1'b1;
      repeat (2) tick();
      s_rst  = 1'b0;
      lfsr_m = Seed;
      model_shuffle();
      wait_ready(1'b1, n);
      s_draw = 1'b1;
      for (int c = 0; c < 5; c++) begin
         s_exp_q.push_back(deck_m[c]);
         tick();
      end
      s_draw = 1'b0;
      chk("shuf cards_left after 5", int'(s_left), 47);

      repeat (3) tick();
      chk("plain queue drained", p_exp_q.size(), 0);
      chk("shuf queue drained", s_exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
